// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared fetch-side constants and the {instn, pc} entry layout
package if_pkg;
  localparam int              XLEN      = 32;
  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP   = 32'd4;
  localparam int              BUF_DEPTH = 2;

  typedef struct packed {
    logic [XLEN-1:0] instn;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_fetch_buf.sv
// rtl/if_fetch_buf.sv - 2-entry fetch FIFO with flush; head is served straight from a register
module if_fetch_buf
  import if_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic [1:0]   count,
  output logic         head_valid,
  output fetch_entry_t head
);
  fetch_entry_t ent1;

  // Upstream credit accounting guarantees no push lands on a full buffer without a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= 2'd0;
      head  <= '0;
      ent1  <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            head <= ent1;
            ent1 <= push_entry;
          end else begin
            head <= push_entry;
          end
        end
        2'b01: begin
          head  <= ent1;
          count <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head  <= push_entry;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            ent1  <= push_entry;
            count <= 2'd2;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = (count != 2'd0);
endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - PC owner: issues fetches under a 2-slot credit rule, tracks the in-flight word, handles redirects
module if_fetch_ctrl
  import if_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  output logic [XLEN-1:0] pc,
  output logic            pc_req,
  input  logic [XLEN-1:0] inp_instn,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instn,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_nextpc,
  output logic [31:0]     fetch_count
);
  logic [XLEN-1:0] pc_reg;
  logic [XLEN-1:0] inflight_pc;
  logic            inflight_v;
  logic [1:0]      buf_count;
  logic            pop;
  logic            push;
  logic [2:0]      slots_used;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  assign pop        = id_valid & id_ready & ~branch_taken;
  assign push       = inflight_v & ~branch_taken;
  // Slots committed after this edge: buffered + returning word - leaving head.
  assign slots_used = {1'b0, buf_count} + {2'b00, inflight_v} - {2'b00, pop};
  assign pc_req     = ~reset & ~branch_taken & (slots_used <= 3'd1);
  assign pc         = pc_reg;

  assign push_entry = '{instn: inp_instn, pc: inflight_pc};
  assign id_instn   = head.instn;
  assign id_pc      = head.pc;
  assign id_nextpc  = head.pc + PC_STEP;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg      <= RESET_PC;
      inflight_v  <= 1'b0;
      inflight_pc <= '0;
    end else if (branch_taken) begin
      pc_reg     <= align_pc(branch_target);
      inflight_v <= 1'b0;
    end else begin
      inflight_v <= pc_req;
      if (pc_req) begin
        inflight_pc <= pc_reg;
        pc_reg      <= pc_reg + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= 32'd0;
    end else if (pop) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  if_fetch_buf u_buf (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (branch_taken),
    .count      (buf_count),
    .head_valid (id_valid),
    .head       (head)
  );
endmodule
